// File: rtl/cache_line_xfer_pkg.sv
// cache_pkg: shared types and constants for the cache line transfer engine.
//   state_e    - engine state (IDLE / XFER / DONE)
//   DEF_*      - default line geometry
//   BYTE_OFF_W - byte-offset bits inside one 32-bit word
//   idx_width  - bits needed to index the words of a line
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WORDS  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int BYTE_OFF_W = 2;

    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/cache_line_xfer_line_buf.sv
// line_buf: WORDS x DATA_W register array.
//   clk, rst        - clock, synchronous active-high clear
//   load, load_line - parallel load of a whole flattened line
//   we, idx, data   - single-word write port
//   line            - flattened read-out, word 0 in the LSBs
module line_buf
    import cache_pkg::*;
#(
    parameter int WORDS  = DEF_WORDS,
    parameter int DATA_W = DEF_DATA_W,
    localparam int IDX_W = idx_width(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [WORDS*DATA_W-1:0] load_line,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]       data,
    output logic [WORDS*DATA_W-1:0] line
);

    logic [DATA_W-1:0] mem_r [WORDS];

    // Storage: clear on reset, whole-line load wins over a single-word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem_r[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < WORDS; i++) mem_r[i] <= load_line[i*DATA_W +: DATA_W];
        end else if (we) begin
            mem_r[idx] <= data;
        end
    end

    // Flatten the array into the read-out bus.
    always_comb begin
        line = '0;
        for (int i = 0; i < WORDS; i++) line[i*DATA_W +: DATA_W] = mem_r[i];
    end

endmodule

// File: rtl/cache_line_xfer.sv
// cache_line_xfer: moves one cache line between the data-cache controller and
// a single-word memory bus, one ack-handshaked beat per word.
//   req_*      - request side (valid/ready, write flag, address, dirty line)
//   fill_line  - assembled fill data, valid with done for a fill
//   done, busy - completion pulse and in-progress flag
//   mem_*      - memory beat interface (strobes held until mem_ack)
// Optional macro CACHE_LINE_XFER_CWF_EN: critical-word-first fills, adding
// crit_valid / crit_data outputs.
module cache_line_xfer
    import cache_pkg::*;
#(
    parameter int WORDS  = DEF_WORDS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [WORDS*DATA_W-1:0] wb_line,
    output logic [WORDS*DATA_W-1:0] fill_line,
    output logic                    done,
    output logic                    busy,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack
`ifdef CACHE_LINE_XFER_CWF_EN
    ,
    output logic                    crit_valid,
    output logic [DATA_W-1:0]       crit_data
`endif
);

    localparam int IDX_W = idx_width(WORDS);
    localparam int OFF_W = IDX_W + BYTE_OFF_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(WORDS - 1);

    state_e                    state_r, state_nxt_s;
    logic [IDX_W-1:0]          beat_r, beat_nxt_s;
    logic [IDX_W-1:0]          idx_r, idx_nxt_s;
    logic                      write_r, write_nxt_s;
    logic [ADDR_W-1:0]         base_r, base_nxt_s;
    logic                      accept_s, beat_ack_s, fill_we_s;
    logic [IDX_W-1:0]          start_idx_s;
    logic [WORDS*DATA_W-1:0]   wb_buf_s, src_line_s;
    logic                      req_ready_nxt_s, busy_nxt_s, done_nxt_s;
    logic                      mem_re_nxt_s, mem_we_nxt_s;
    logic [ADDR_W-1:0]         mem_addr_nxt_s;
    logic [DATA_W-1:0]         mem_wdata_nxt_s;
    logic                      unused_addr_s;

    // Byte-offset bits only matter for the critical-word start index.
    assign unused_addr_s = ^req_addr[OFF_W-1:0];

    assign accept_s   = (state_r == IDLE) && req_valid;
    // mem_ack only counts while a strobe is up, i.e. in XFER.
    assign beat_ack_s = (state_r == XFER) && mem_ack;
    assign fill_we_s  = beat_ack_s && !write_r;

    line_buf #(.WORDS(WORDS), .DATA_W(DATA_W)) u_wb_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .load_line (wb_line),
        .we        (1'b0),
        .idx       ({IDX_W{1'b0}}),
        .data      ({DATA_W{1'b0}}),
        .line      (wb_buf_s)
    );

    line_buf #(.WORDS(WORDS), .DATA_W(DATA_W)) u_fill_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_line ({(WORDS*DATA_W){1'b0}}),
        .we        (fill_we_s),
        .idx       (idx_r),
        .data      (mem_rdata),
        .line      (fill_line)
    );

    // Start index: critical word for fills when enabled, otherwise word 0.
    always_comb begin
`ifdef CACHE_LINE_XFER_CWF_EN
        if (req_write) begin
            start_idx_s = '0;
        end else begin
            start_idx_s = req_addr[OFF_W-1:BYTE_OFF_W];
        end
`else
        start_idx_s = '0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            beat_r  <= '0;
            idx_r   <= '0;
            write_r <= 1'b0;
            base_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            idx_r   <= idx_nxt_s;
            write_r <= write_nxt_s;
            base_r  <= base_nxt_s;
        end
    end

    // Next-state logic: accept, advance on each acked beat, one DONE cycle.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        idx_nxt_s   = idx_r;
        write_nxt_s = write_r;
        base_nxt_s  = base_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = XFER;
                    write_nxt_s = req_write;
                    base_nxt_s  = req_addr & LINE_MASK;
                    beat_nxt_s  = '0;
                    idx_nxt_s   = start_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                if (mem_ack && (beat_r == LAST_BEAT)) begin
                    state_nxt_s = DONE;
                end else if (mem_ack) begin
                    beat_nxt_s = beat_r + IDX_W'(1);
                    idx_nxt_s  = idx_r + IDX_W'(1);  // wraps modulo WORDS
                end else begin
                    state_nxt_s = XFER;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        // On the accept edge the write-back buffer is still loading.
        src_line_s      = accept_s ? wb_line : wb_buf_s;
        req_ready_nxt_s = (state_nxt_s == IDLE);
        busy_nxt_s      = (state_nxt_s != IDLE);
        done_nxt_s      = (state_nxt_s == DONE);
        mem_re_nxt_s    = (state_nxt_s == XFER) && !write_nxt_s;
        mem_we_nxt_s    = (state_nxt_s == XFER) && write_nxt_s;
        if (state_nxt_s == XFER) begin
            mem_addr_nxt_s = base_nxt_s + ADDR_W'({idx_nxt_s, 2'b00});
        end else begin
            mem_addr_nxt_s = '0;
        end
        if (mem_we_nxt_s) begin
            mem_wdata_nxt_s = src_line_s[idx_nxt_s*DATA_W +: DATA_W];
        end else begin
            mem_wdata_nxt_s = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= req_ready_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
            mem_re    <= mem_re_nxt_s;
            mem_we    <= mem_we_nxt_s;
            mem_addr  <= mem_addr_nxt_s;
            mem_wdata <= mem_wdata_nxt_s;
        end
    end

`ifdef CACHE_LINE_XFER_CWF_EN
    // Critical word: pulse after the first fill beat, hold data until next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= fill_we_s && (beat_r == '0);
            if (fill_we_s && (beat_r == '0)) begin
                crit_data <= mem_rdata;
            end else if (accept_s) begin
                crit_data <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_xfer.sv
// Scoreboard bench for cache_line_xfer: the driver pushes expected transfers,
// a memory responder answers beats, and a monitor checks every cycle.
module tb_cache_line_xfer;

    localparam int WORDS = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LW    = WORDS * DW;
`ifdef CACHE_LINE_XFER_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk, rst, req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr, mem_addr;
    logic [LW-1:0] wb_line, fill_line;
    logic          done, busy, mem_re, mem_we, mem_ack;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef CACHE_LINE_XFER_CWF_EN
    logic          crit_valid;
    logic [DW-1:0] crit_data;
`endif

    cache_line_xfer #(.WORDS(WORDS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .wb_line(wb_line),
        .fill_line(fill_line), .done(done), .busy(busy), .mem_re(mem_re),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_LINE_XFER_CWF_EN
        , .crit_valid(crit_valid), .crit_data(crit_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory contents: responder view and model view -------
    bit [31:0] mem     [int unsigned];
    bit [31:0] ref_mem [int unsigned];

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit [31:0] rd_mem(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic bit [31:0] rd_ref(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    typedef struct {
        bit          write;
        bit [31:0]   base;
        int          start;
        bit [LW-1:0] line;
        bit          zero_wait;
    } txn_t;

    txn_t exp_q[$];

    // ---------------- memory responder -------------------------------------
    int wait_mode = 0;   // 0: ack at once, 1: two wait cycles, 2: random 0..2
    bit spur_ack  = 1'b0;

    initial begin
        int cnt, tgt;
        bit was_strobe, prev_ack;
        cnt = 0; tgt = 0; was_strobe = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            prev_ack = mem_ack;
            mem_ack = 1'b0;
            if (mem_re || mem_we) begin
                if (!was_strobe || prev_ack) begin
                    cnt = 0;
                    tgt = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 2 : int'($urandom_range(0, 2));
                end
                if (cnt >= tgt) begin
                    mem_ack = 1'b1;
                    if (mem_re) begin
                        mem_rdata = rd_mem(mem_addr);
                    end else begin
                        mem[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end
                end else begin
                    cnt++;
                    mem_rdata = $urandom;
                end
                was_strobe = 1'b1;
            end else begin
                was_strobe = 1'b0;
                mem_ack = spur_ack;
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ---------------------------------
    bit          active = 1'b0;
    txn_t        cur;
    int          beat_i = 0;
    int          acc_edge = 0;
    int          last_ack_edge = 0;
    int          crit_edge = -1;
    bit [LW-1:0] last_fill = '0;
    bit          rst_pending = 1'b0;
    bit          prev_valid = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;

    initial forever begin
        logic strobe, other;
        int   idx;
        @(negedge clk);
        if (rst_pending) begin
            check("rst_mem_re", mem_re, 1'b0);
            check("rst_mem_we", mem_we, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_req_ready", req_ready, 1'b1);
            check("rst_fill_line", fill_line, '0);
            rst_pending = 1'b0;
        end
        if (rst) begin
            active = 1'b0;
            last_fill = '0;
            crit_edge = -1;
            rst_pending = 1'b1;
            prev_valid = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
        end else begin
            if (active) begin
                strobe = cur.write ? mem_we : mem_re;
                other  = cur.write ? mem_re : mem_we;
                check("busy_in_xfer", busy, 1'b1);
                check("ready_in_xfer", req_ready, 1'b0);
                check("wrong_strobe", other, 1'b0);
                if (!done) begin
                    check("strobe_held", strobe, 1'b1);
                    if (strobe && mem_ack) begin
                        idx = (cur.start + beat_i) % WORDS;
                        check("beat_addr", mem_addr, cur.base + 32'(4 * idx));
                        if (cur.write) check("beat_wdata", mem_wdata, cur.line[idx*DW +: DW]);
                        if (!cur.write && beat_i == 0) crit_edge = cyc + 1;
                        beat_i++;
                        last_ack_edge = cyc + 1;
                    end
                end else begin
                    check("done_beats", beat_i, WORDS);
                    check("done_timing", cyc, last_ack_edge);
                    if (cur.zero_wait) check("zero_wait_latency", cyc - acc_edge, WORDS);
                    check("done_strobe", strobe, 1'b0);
                    if (!cur.write) last_fill = cur.line;
                    check("fill_line", fill_line, last_fill);
                    active = 1'b0;
                end
            end else begin
                check("idle_done", done, 1'b0);
                check("idle_mem_re", mem_re, 1'b0);
                check("idle_mem_we", mem_we, 1'b0);
                check("idle_busy", busy, 1'b0);
                check("idle_ready", req_ready, 1'b1);
                check("idle_fill_line", fill_line, last_fill);
            end
`ifdef CACHE_LINE_XFER_CWF_EN
            check("crit_valid", crit_valid, crit_edge == cyc);
            if (crit_edge == cyc) check("crit_data", crit_data, cur.line[cur.start*DW +: DW]);
`endif
            if (req_valid && req_ready) begin
                if (prev_valid && prev_busy) check("held_accept_after_done", prev_done, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 1'b1, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    beat_i = 0;
                    acc_edge = cyc + 1;
                    last_ack_edge = -1;
                    crit_edge = -1;
                end
            end
            prev_valid = req_valid; prev_busy = busy; prev_done = done;
        end
    end

    // ---------------- driver ------------------------------------------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input bit w, input bit [31:0] a, input bit [LW-1:0] wl,
                        input int wm, input bit keep);
        txn_t t;
        bit   got;
        t.write = w;
        t.base  = a & 32'hFFFF_FFF0;
        t.start = (CWF && !w) ? int'(a[3:2]) : 0;
        t.zero_wait = (wm == 0);
        for (int i = 0; i < WORDS; i++) begin
            if (w) begin
                t.line[i*DW +: DW] = wl[i*DW +: DW];
                ref_mem[t.base + 32'(4 * i)] = wl[i*DW +: DW];
            end else begin
                t.line[i*DW +: DW] = rd_ref(t.base + 32'(4 * i));
            end
        end
        wait_mode = wm;
        req_valid = 1'b1; req_write = w; req_addr = a; wb_line = wl;
        exp_q.push_back(t);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clk);
            #1;
            idle = !active && exp_q.size() == 0 && !req_valid;
        end
        if (!idle) check("idle_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit [LW-1:0] line_a, wl;
        bit          keep, prev_keep;
        int          wm;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; wb_line = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_mem_re", mem_re, 1'b0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_fill_line", fill_line, '0);
        @(posedge clk);
        #1;

        // Directed fill, zero-wait memory.
        for (int i = 0; i < WORDS; i++) begin
            mem[32'h1040 + 32'(4 * i)]     = 32'hA0 + 32'(i);
            ref_mem[32'h1040 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end
        line_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        send(1'b0, 32'h0000_1048, '0, 0, 1'b0);
        wait_idle();
        check("directed_fill_line", fill_line, line_a);

        // Directed write-back, two wait cycles per beat.
        send(1'b1, 32'h0000_5004, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 1'b0);
        wait_idle();
        check("wb_keeps_fill_line", fill_line, line_a);
        check("wb_mem_word0", mem[32'h5000], 32'h11);
        check("wb_mem_word3", mem[32'h500C], 32'h44);

        // Reset during beat 2 of a fill, then a normal fill.
        send(1'b0, 32'h0000_3004, '0, 0, 1'b0);
        for (int k = 0; k < 50 && !(active && beat_i == 2); k++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(1'b0, 32'h0000_3008, '0, 2, 1'b0);
        wait_idle();

        // Spurious acks in IDLE, and a request held while busy.
        spur_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 32'h0000_1044, '0, 0, 1'b1);
        send(1'b1, 32'h0000_1040, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 1'b0);
        wait_idle();
        send(1'b0, 32'h0000_104C, '0, 0, 1'b0);
        wait_idle();
        check("fill_after_wb", fill_line, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        spur_ack = 1'b0;

        // Randomized mix of fills and write-backs over a small address window.
        prev_keep = 1'b0;
        wm = 0;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < WORDS; i++) wl[i*DW +: DW] = $urandom;
            if (!prev_keep) wm = int'($urandom_range(0, 2));
            keep = ($urandom_range(0, 3) == 0);
            spur_ack = $urandom_range(0, 1) == 1;
            send(1'($urandom_range(0, 1)), 32'h2000 | 32'($urandom_range(0, 255)), wl, wm, keep);
            if (!keep) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            prev_keep = keep;
        end
        req_valid = 1'b0;
        wait_idle();
        spur_ack = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_line_xfer.md
Name: cache_line_xfer

Overview:
- Line-transfer engine between the data-cache controller and main memory.
- Accepts one fill (read) or write-back request per cache miss and moves a full line of WORDS words over a single-word memory bus, using a per-beat ack handshake.
- Returns the assembled fill line with a one-cycle done pulse.
- Replaces the controller's fixed 4-count wait with a real completion handshake.

Parameters:
- WORDS, 4: words per cache line; power of two, ≥2.
- DATA_W, 32: word width in bits.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  controller requests a transfer.
- req_ready  out  1  engine can accept a request (IDLE only).
- req_write  in  1  1 = write-back of wb_line; 0 = fill.
- req_addr  in  ADDR_W  any byte address inside the target line.
- wb_line  in  WORDS*DATA_W  dirty line, word 0 in the LSBs; sampled at accept.
- fill_line  out  WORDS*DATA_W  assembled fill data; valid when done=1 for a fill.
- done  out  1  one-cycle pulse on transfer completion.
- busy  out  1  high from the cycle after accept until done.
- mem_re  out  1  memory read strobe, held until mem_ack.
- mem_we  out  1  memory write strobe, held until mem_ack.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  DATA_W  beat write data.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  beat complete.

Behaviour:
- Reset: all outputs except req_ready are 0.
  - state=IDLE, beat=0, fill_line=0.
  - req_ready=1 in the cycle after rst deasserts.
- Reset mid-transfer: on the same edge, return to IDLE and drop mem_re/mem_we. Partial fill data is discarded and no done pulse is issued.
- Line base address: req_addr with its low log2(WORDS)+2 bits cleared.
  - Beat address = base + 4*idx.
  - idx is log2(WORDS) bits wide and wraps modulo WORDS.
- State machine (registered outputs):
  - IDLE:
    - req_ready=1.
    - req_valid=1 latches req_write, base, wb_line and the start index, then goes to XFER.
    - Request accepted at edge N → strobe visible in cycle N+1.
  - XFER:
    - Exactly one of mem_re (fill) or mem_we (write-back) is high.
    - mem_addr and mem_wdata reflect the current idx.
    - On mem_ack:
      - A fill writes mem_rdata into fill_line word idx.
      - If beat==WORDS-1, go to DONE; otherwise beat+1 and idx+1, and the strobe stays high with the new address next cycle (back-to-back beats allowed).
    - The strobe must not drop between beats.
  - DONE:
    - done=1 for exactly one cycle; req_ready=0 in this cycle; fill_line is stable.
    - Then go to IDLE.
- Latency with zero-wait memory (ack in the first strobe cycle): accept edge N → done in cycle N+WORDS+1.
- fill_line holds its value until the next fill's first ack.
- Write-back leaves fill_line unchanged.
- req_valid while not IDLE: ignored, no queuing; the controller must hold it.
- mem_ack while no strobe is active: ignored.
- busy = state is XFER or DONE.

Optional Feature:
- Macro: CACHE_LINE_XFER_CWF_EN (critical-word-first for fills).
- With the macro:
  - A fill's start idx = req_addr[log2(WORDS)+1:2]; beats wrap, e.g. idx 2,3,0,1.
  - Extra output crit_valid (1 bit) pulses in the cycle after the first fill beat's ack.
  - Extra output crit_data (DATA_W) holds that word from the crit_valid cycle until the next accept.
  - Write-backs always start at idx 0.
- Without the macro: start idx is always 0 and neither crit port exists.

Decomposition:
- Package cache_pkg:
  - State enum IDLE/XFER/DONE.
  - Default WORDS/DATA_W/ADDR_W constants.
  - Byte-offset width constant.
- Sub-module line_buf: WORDS x DATA_W register array with a write port (idx, data, we) and a flattened read-out. Used for both the wb_line capture and fill_line assembly.

Test Plan:
- Reset then idle 3 cycles → req_ready=1; mem_re=mem_we=done=0; fill_line=0.
- Fill, req_addr=0x0000_1048, ack every cycle, rdata=0xA0..0xA3 → mem_addr 0x1040,0x1044,0x1048,0x104C; fill_line={A3,A2,A1,A0}; done at N+5.
- Write-back, wb_line words 0x11,0x22,0x33,0x44, ack after 2 wait cycles per beat → mem_we stays high continuously; wdata order 11,22,33,44; done once; fill_line unchanged.
- rst asserted during beat 2 of a fill → next cycle mem_re=0, busy=0, req_ready=1, no done; new fill then completes normally.
- req_valid held during busy, plus spurious mem_ack in IDLE → second request accepted only in the cycle after the first done pulse ends; spurious ack causes no state change.
- With CACHE_LINE_XFER_CWF_EN, fill req_addr=0x1048 → beat addresses 0x1048,0x104C,0x1040,0x1044; crit_valid one cycle after first ack; crit_data=first rdata.
